// File: rtl/add_nibble_serial_pkg.sv
// Shared types for the nibble-serial adder.
// State encodings and the nibble width used by the datapath.
package add_nibble_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add_nibble_serial_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// master = producer/consumer side, slave = adder side.
interface add_nibble_serial_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
  );

endinterface

// File: rtl/add_nibble_serial_add4bit.sv
// 4-bit ripple adder slice reused once per nibble.
// Combinational only.
module add4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0, c_in};

endmodule

// File: rtl/add_nibble_serial.sv
// WIDTH-bit adder that streams one nibble per cycle through add4bit.
// Registered carry links the nibbles; valid/ready on both sides.
module add_nibble_serial
  import add_nibble_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  add_nibble_serial_if.slave io
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW      = $clog2(NIBBLES);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_co;
  logic [WIDTH-1:0]    sum_shift;
  logic                last;

  add4bit u_add4 (
    .a     (a_sr_q[NIBBLE_W-1:0]),
    .b     (b_sr_q[NIBBLE_W-1:0]),
    .c_in  (carry_q),
    .sum   (nib_sum),
    .c_out (nib_co)
  );

  // New nibble enters at the MSB so the LSB nibble lands at the bottom.
  assign sum_shift = {nib_sum, sum_sr_q[WIDTH-1:NIBBLE_W]};
  assign last      = (idx_q == IW'(NIBBLES - 1));

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    c_out_d  = c_out_q;
    idx_d    = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (io.in_valid) begin
          a_sr_d  = io.a;
          b_sr_d  = io.b;
          carry_d = io.c_in;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_sr_d = sum_shift;
        a_sr_d   = a_sr_q >> NIBBLE_W;
        b_sr_d   = b_sr_q >> NIBBLE_W;
        carry_d  = nib_co;
        idx_d    = idx_q + IW'(1);
        if (last) begin
          sum_d   = sum_shift;
          c_out_d = nib_co;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (io.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      c_out_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      c_out_q  <= c_out_d;
      idx_q    <= idx_d;
    end
  end

  assign io.in_ready  = (state_q == ST_IDLE);
  assign io.out_valid = (state_q == ST_DONE);
  assign io.sum       = sum_q;
  assign io.c_out     = c_out_q;

endmodule

// File: tb/tb_add_nibble_serial.sv
// Directed + random bench for add_nibble_serial (WIDTH=16).
// Reference is plain 17-bit addition of the operands.
module tb_add_nibble_serial;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_hs    = 0;

  add_nibble_serial_if #(.WIDTH(WIDTH)) io ();

  add_nibble_serial #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && io.out_valid === 1'b1 && io.out_ready === 1'b1)
      n_hs++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input int stall);
    logic [16:0] ref_v;
    int lat;
    int lowc;
    bit got;
    ref_v = {1'b0, a} + {1'b0, b} + 17'(ci);
    @(posedge clk); #1;
    io.a         = a;
    io.b         = b;
    io.c_in      = ci;
    io.in_valid  = 1'b1;
    io.out_ready = (stall == 0);
    @(negedge clk);
    chk("in_ready_idle", io.in_ready, 1);
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    n_acc++;
    lat  = 0;
    lowc = 0;
    got  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!io.in_ready) lowc++;
      if (io.out_valid) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_seen", got, 1);
    if (!got) return;
    chk("latency", lat, NIB);
    chk("sum", io.sum, ref_v[15:0]);
    chk("c_out", io.c_out, ref_v[16]);
    for (int i = 1; i <= stall; i++) begin
      @(posedge clk); #1;
      io.in_valid = 1'b1;
      io.a        = 16'h1111;
      io.b        = 16'h1111;
      io.c_in     = 1'b1;
      if (i == stall) io.out_ready = 1'b1;
      @(negedge clk);
      if (!io.in_ready) lowc++;
      chk("hold_valid", io.out_valid, 1);
      chk("hold_sum", io.sum, ref_v[15:0]);
      chk("hold_cout", io.c_out, ref_v[16]);
    end
    @(posedge clk); #1;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    @(negedge clk);
    chk("back_idle", io.in_ready, 1);
    chk("valid_drop", io.out_valid, 0);
    chk("sum_kept", io.sum, ref_v[15:0]);
    chk("busy_cycles", lowc, NIB + 1 + stall);
  endtask

  initial begin
    io.in_valid  = 1'b0;
    io.a         = '0;
    io.b         = '0;
    io.c_in      = 1'b0;
    io.out_ready = 1'b0;
    #2;
    chk("rst_in_ready", io.in_ready, 1);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_sum", io.sum, 0);
    chk("rst_cout", io.c_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(16'h0000, 16'h0000, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'h1234, 16'h4321, 1'b1, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 5);
    run_op(16'h1111, 16'h2222, 1'b0, 0);

    // abandon an operation two cycles into RUN
    @(posedge clk); #1;
    io.a        = 16'h1234;
    io.b        = 16'h4321;
    io.c_in     = 1'b0;
    io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", io.out_valid, 0);
    chk("mid_rst_ready", io.in_ready, 1);
    chk("mid_rst_sum", io.sum, 0);
    chk("mid_rst_cout", io.c_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(16'h00FF, 16'h0001, 1'b0, 0);

    for (int n = 0; n < 1000; n++) begin
      run_op(16'($urandom), 16'($urandom),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    chk("handshakes", n_hs, n_acc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
